// File: rtl/skinny_sbox_layer_ctrl.sv
`default_nettype none
// ============================================================================
// skinny_sbox_layer_ctrl : runs masked SKINNY SubCells through one shared
//                          two-share S-box, one byte at a time.
// Revision: 1.0
// ============================================================================
module skinny_sbox_layer_ctrl #(
  parameter int LAT = 12,
  parameter int NB  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [8*NB-1:0] st0_i,
  input  logic [8*NB-1:0] st1_i,
  input  logic [7:0]      rnd_i,
  input  logic            rnd_valid_i,
  output logic            rnd_ready_o,
  output logic [7:0]      sb_in0_o,
  output logic [7:0]      sb_in1_o,
  output logic [7:0]      sb_r_o,
  input  logic [7:0]      sb_out0_i,
  input  logic [7:0]      sb_out1_i,
  output logic [8*NB-1:0] st0_o,
  output logic [8*NB-1:0] st1_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8*NB-1:0] st0_q, st0_d;
  logic [8*NB-1:0] st1_q, st1_d;
  logic [7:0]      sb_in0_q, sb_in0_d;
  logic [7:0]      sb_in1_q, sb_in1_d;
  logic [7:0]      sb_r_q, sb_r_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    st0_d    = st0_q;
    st1_d    = st1_q;
    sb_in0_d = sb_in0_q;
    sb_in1_d = sb_in1_q;
    sb_r_d   = sb_r_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          st0_d   = st0_i;
          st1_d   = st1_i;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // S-box operands and fresh mask are captured together so they stay aligned
        if (rnd_valid_i) begin
          sb_r_d   = rnd_i;
          sb_in0_d = st0_q[{idx_q, 3'b000} +: 8];
          sb_in1_d = st1_q[{idx_q, 3'b000} +: 8];
          cnt_d    = '0;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        st0_d[{idx_q, 3'b000} +: 8] = sb_out0_i;
        st1_d[{idx_q, 3'b000} +: 8] = sb_out1_i;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      st0_q    <= '0;
      st1_q    <= '0;
      sb_in0_q <= '0;
      sb_in1_q <= '0;
      sb_r_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      st0_q    <= st0_d;
      st1_q    <= st1_d;
      sb_in0_q <= sb_in0_d;
      sb_in1_q <= sb_in1_d;
      sb_r_q   <= sb_r_d;
    end
  end

  assign rnd_ready_o = (state_q == S_FETCH);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign sb_in0_o    = sb_in0_q;
  assign sb_in1_o    = sb_in1_q;
  assign sb_r_o      = sb_r_q;
  assign st0_o       = st0_q;
  assign st1_o       = st1_q;

endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox_layer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_skinny_sbox_layer_ctrl : directed bench with a behavioural masked S-box.
// Revision: 1.0
// ============================================================================
module tb_skinny_sbox_layer_ctrl;

  localparam int LAT = 12;
  localparam int NB  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] st0_i = '0;
  logic [127:0] st1_i = '0;
  logic [7:0]   rnd_i = '0;
  logic         rnd_valid_i = 1'b0;
  logic         rnd_ready_o;
  logic [7:0]   sb_in0_o, sb_in1_o, sb_r_o;
  logic [7:0]   sb_out0_i, sb_out1_i;
  logic [127:0] st0_o, st1_o;
  logic         busy_o, done_o;

  int vectors = 0;
  int errors  = 0;
  int age     = 1000;
  int hs_cnt  = 0;
  int hs_base = 0;
  logic [127:0] cur0 = '0;
  logic [127:0] cur1 = '0;
  logic [7:0]   exp_in0 = '0, exp_in1 = '0, exp_r = '0;

  skinny_sbox_layer_ctrl #(.LAT(LAT), .NB(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .st0_i       (st0_i),
    .st1_i       (st1_i),
    .rnd_i       (rnd_i),
    .rnd_valid_i (rnd_valid_i),
    .rnd_ready_o (rnd_ready_o),
    .sb_in0_o    (sb_in0_o),
    .sb_in1_o    (sb_in1_o),
    .sb_r_o      (sb_r_o),
    .sb_out0_i   (sb_out0_i),
    .sb_out1_i   (sb_out1_i),
    .st0_o       (st0_o),
    .st1_o       (st1_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb_mix(input logic [7:0] x);
    logic [7:0] t;
    t = ((x >> 1) | x) >> 2;
    t = ~t;
    return (t & 8'h11) ^ x;
  endfunction

  function automatic logic [7:0] sb_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] y;
    y = sb_mix(x);
    y = sb_mix(sb_perm(y));
    y = sb_mix(sb_perm(y));
    y = sb_mix(sb_perm(y));
    return (y & 8'hF9) | ((y >> 1) & 8'h02) | ((y << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] lut128(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[k*8 +: 8] = sbox8(x[k*8 +: 8]);
    return y;
  endfunction

  // Masked S-box model: output is only correct once inputs have been held LAT cycles
  assign sb_out0_i = (age >= LAT) ? (sb_r_o ^ 8'h5A) : 8'h3C;
  assign sb_out1_i = (age >= LAT) ? (sbox8(sb_in0_o ^ sb_in1_o) ^ sb_r_o ^ 8'h5A) : 8'h00;

  always @(posedge clk) begin
    if (rnd_ready_o && rnd_valid_i) begin
      exp_in0 <= cur0[((hs_cnt - hs_base) & 15) * 8 +: 8];
      exp_in1 <= cur1[((hs_cnt - hs_base) & 15) * 8 +: 8];
      exp_r   <= rnd_i;
      age     <= 0;
      hs_cnt  <= hs_cnt + 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode: 0 nominal, 1 throttled randomness, 2 start while busy, 3 reset at cycle 100
  task automatic run(input logic [127:0] x, input int mode);
    logic [127:0] m;
    int n, stalls;
    m = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    st0_i = m; st1_i = x ^ m; cur0 = m; cur1 = x ^ m;
    hs_base = hs_cnt; start_i = 1'b1; rnd_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; n = 1; stalls = 0;
    while (!done_o && n < 1000) begin
      if (busy_o && age <= LAT)
        check("hold_stable", {rnd_ready_o, sb_in0_o, sb_in1_o, sb_r_o},
              {1'b0, exp_in0, exp_in1, exp_r});
      if (mode == 2 && n == 50) begin start_i = 1'b1; st0_i = ~m; st1_i = m; end
      if (mode == 2 && n == 51) start_i = 1'b0;
      if (mode == 2 && n == 224) begin start_i = 1'b1; st0_i = m ^ 128'h1; end
      if (mode == 3 && n == 100) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {busy_o, done_o, rnd_ready_o, sb_in0_o, sb_in1_o, sb_r_o}, '0);
        check("rst_state", {st0_o, st1_o}, '0);
        repeat (20) begin
          @(negedge clk);
          check("rst_no_done", {done_o, busy_o}, '0);
        end
        rst_n = 1'b1;
        return;
      end
      rnd_i = 8'($urandom);
      rnd_valid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_ready_o && !rnd_valid_i) stalls++;
      @(negedge clk);
      n++;
    end
    check("latency", n, 225 + stalls);
    check("done_high", done_o, 1'b1);
    check("result", st0_o ^ st1_o, lut128(x));
    check("handshakes", hs_cnt - hs_base, NB);
    @(negedge clk);
    start_i = 1'b0;
    check("done_pulse", {done_o, busy_o}, 2'b00);
    repeat (3) @(negedge clk);
    check("idle_hold", {busy_o, st0_o ^ st1_o}, {1'b0, lut128(x)});
  endtask

  initial begin
    logic [127:0] x;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy_o, done_o, rnd_ready_o, sb_in0_o, sb_in1_o, sb_r_o}, '0);
    check("reset_state", {st0_o, st1_o}, '0);
    rst_n = 1'b1;

    x = 128'h0f0e0d0c0b0a09080706050403020100;
    run(x, 0);
    run(128'h0123456789abcdeffedcba9876543210, 1);
    run(x, 2);
    run(x, 3);
    run(x, 0);
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) x[k*8 +: 8] = 8'(16 * r + k);
      run(x, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
